// File: rtl/rdout_fifo_arbiter.sv
// Merges two readout streams into one output FIFO through private elastic buffers
// and a round-robin arbiter with a burst limit; each output word carries its source id.
module rdout_fifo_arbiter #(
  parameter int unsigned READOUT_WIDTH_G  = 32,
  parameter int unsigned DEPTH_G          = 4,
  parameter int unsigned ALMST_FULL_THR_G = 1,
  parameter int unsigned MAX_BURST_G      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       src0_fifo_wr_i,
  input  logic [READOUT_WIDTH_G-1:0] src0_fifo_data_i,
  output logic                       src0_fifo_full_o,
  output logic                       src0_fifo_almst_full_o,
  input  logic                       src1_fifo_wr_i,
  input  logic [READOUT_WIDTH_G-1:0] src1_fifo_data_i,
  output logic                       src1_fifo_full_o,
  output logic                       src1_fifo_almst_full_o,
  input  logic                       out_fifo_full_i,
  input  logic                       out_fifo_almst_full_i,
  output logic                       out_fifo_wr_o,
  output logic [READOUT_WIDTH_G:0]   out_fifo_data_o,
  output logic [1:0]                 overflow_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH_G);
  localparam int unsigned CNT_W  = $clog2(DEPTH_G + 1);
  localparam int unsigned BCNT_W = $clog2(MAX_BURST_G + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH_G);
  localparam logic [CNT_W-1:0]  AFULL_CNT = CNT_W'(DEPTH_G - ALMST_FULL_THR_G);
  localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(MAX_BURST_G);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  logic [1:0]                 wr;
  logic [READOUT_WIDTH_G-1:0] wdata     [2];
  logic [READOUT_WIDTH_G-1:0] mem       [2][DEPTH_G];
  logic [PTR_W-1:0]           wr_ptr    [2];
  logic [PTR_W-1:0]           rd_ptr    [2];
  logic [CNT_W-1:0]           count_q   [2];
  logic [CNT_W-1:0]           count_nxt [2];
  logic [1:0]                 full_q, afull_q, ovf_q;
  logic [1:0]                 push_c, pop_c, ne_c;

  state_t                     state_q, state_nxt;
  logic [BCNT_W-1:0]          bcnt_q, bcnt_nxt;
  logic                       last_q, last_nxt;
  logic                       own_c, sel_c, grant_c;
  logic [READOUT_WIDTH_G:0]   out_data_c;
  logic                       out_wr_q;
  logic [READOUT_WIDTH_G:0]   out_data_q;

  // Downstream full is advisory only; flow control uses almost-full.
  logic unused_out_full;
  assign unused_out_full = out_fifo_full_i;

  assign wr       = {src1_fifo_wr_i, src0_fifo_wr_i};
  assign wdata[0] = src0_fifo_data_i;
  assign wdata[1] = src1_fifo_data_i;

  assign src0_fifo_full_o       = full_q[0];
  assign src0_fifo_almst_full_o = afull_q[0];
  assign src1_fifo_full_o       = full_q[1];
  assign src1_fifo_almst_full_o = afull_q[1];
  assign overflow_o             = ovf_q;
  assign out_fifo_wr_o          = out_wr_q;
  assign out_fifo_data_o        = out_data_q;

  // Buffer occupancy bookkeeping; a write to a full buffer is dropped even if it pops.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      ne_c[n]      = (count_q[n] != '0);
      push_c[n]    = wr[n] & ~full_q[n];
      count_nxt[n] = count_q[n] + CNT_W'(push_c[n]) - CNT_W'(pop_c[n]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr[n]  <= '0;
        rd_ptr[n]  <= '0;
        count_q[n] <= '0;
      end
      full_q  <= '0;
      afull_q <= '0;
      ovf_q   <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push_c[n]) wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
        if (pop_c[n])  rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
        if (wr[n] && full_q[n]) ovf_q[n] <= 1'b1;
        count_q[n] <= count_nxt[n];
        full_q[n]  <= (count_nxt[n] == FULL_CNT);
        afull_q[n] <= (count_nxt[n] >= AFULL_CNT);
      end
    end
  end

  // Storage needs no reset; occupancy counts gate every read.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 2; n++) begin
      if (push_c[n]) mem[n][wr_ptr[n]] <= wdata[n];
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_nxt;
      bcnt_q  <= bcnt_nxt;
      last_q  <= last_nxt;
    end
  end

  // Next-state: owner keeps the output until its burst limit is hit with the other side waiting.
  always_comb begin
    state_nxt = state_q;
    bcnt_nxt  = bcnt_q;
    last_nxt  = last_q;
    own_c     = (state_q == OWN1);
    sel_c     = 1'b0;
    grant_c   = 1'b0;
    if (!out_fifo_almst_full_i) begin
      case (state_q)
        OWN0, OWN1: begin
          if (ne_c[own_c] && !(bcnt_q == BCNT_MAX && ne_c[~own_c])) begin
            sel_c   = own_c;
            grant_c = 1'b1;
          end else if (ne_c[~own_c]) begin
            sel_c   = ~own_c;
            grant_c = 1'b1;
          end
        end
        default: begin
          if (ne_c[0] && ne_c[1]) begin
            sel_c   = ~last_q;
            grant_c = 1'b1;
          end else if (ne_c[0] || ne_c[1]) begin
            sel_c   = ne_c[1];
            grant_c = 1'b1;
          end
        end
      endcase
      if (grant_c) begin
        state_nxt = sel_c ? OWN1 : OWN0;
        last_nxt  = sel_c;
        if (state_q != IDLE && sel_c == own_c)
          bcnt_nxt = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BCNT_W'(1);
        else
          bcnt_nxt = BCNT_W'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Output decode: pop strobes and the tagged word to register.
  always_comb begin
    pop_c      = 2'b00;
    out_data_c = {sel_c, mem[sel_c][rd_ptr[sel_c]]};
    if (grant_c) pop_c = sel_c ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_wr_q <= grant_c;
      if (grant_c) out_data_q <= out_data_c;
    end
  end

endmodule

// File: tb/tb_rdout_fifo_arbiter.sv
// Randomised and directed bench for rdout_fifo_arbiter: a queue-based reference model
// feeds a scoreboard that a negedge monitor checks against the DUT.
module tb_rdout_fifo_arbiter;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int THR   = 1;
  localparam int MAXB  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src0_wr = 1'b0, src1_wr = 1'b0;
  logic [W-1:0]  src0_data = '0, src1_data = '0;
  logic          src0_full, src0_afull, src1_full, src1_afull;
  logic          out_full = 1'b0, out_afull = 1'b0;
  logic          out_wr;
  logic [W:0]    out_data;
  logic [1:0]    overflow;

  rdout_fifo_arbiter #(
    .READOUT_WIDTH_G(W), .DEPTH_G(DEPTH), .ALMST_FULL_THR_G(THR), .MAX_BURST_G(MAXB)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .src0_fifo_wr_i(src0_wr), .src0_fifo_data_i(src0_data),
    .src0_fifo_full_o(src0_full), .src0_fifo_almst_full_o(src0_afull),
    .src1_fifo_wr_i(src1_wr), .src1_fifo_data_i(src1_data),
    .src1_fifo_full_o(src1_full), .src1_fifo_almst_full_o(src1_afull),
    .out_fifo_full_i(out_full), .out_fifo_almst_full_i(out_afull),
    .out_fifo_wr_o(out_wr), .out_fifo_data_o(out_data), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // Reference state: per-source word queues, current owner (-1 = none), run length, last served.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W:0]   sb[$];
  int           own = -1, run = 0, last = 1;
  bit           exp_wr = 1'b0;
  logic [W:0]   exp_data = '0;
  logic [1:0]   exp_ovf = '0;
  bit           armed = 1'b0;
  int           n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model, evaluated once per rising edge from the inputs applied during that cycle.
  always @(posedge clk) begin : model
    int n0, n1, s;
    bit ne0, ne1;
    logic [W-1:0] w;
    if (rst) begin
      q0.delete(); q1.delete(); sb.delete();
      own = -1; run = 0; last = 1;
      exp_wr = 1'b0; exp_data = '0; exp_ovf = '0;
    end else begin
      n0 = q0.size();
      n1 = q1.size();
      ne0 = (n0 > 0);
      ne1 = (n1 > 0);
      s = -1;
      if (!out_afull) begin
        if (own == 0 && ne0 && !(run == MAXB && ne1))      s = 0;
        else if (own == 1 && ne1 && !(run == MAXB && ne0)) s = 1;
        else if (ne0 && ne1)                               s = (own < 0) ? 1 - last : 1 - own;
        else if (ne0)                                      s = 0;
        else if (ne1)                                      s = 1;
        if (s < 0) own = -1;
      end
      exp_wr = (s >= 0);
      if (s >= 0) begin
        w = (s == 1) ? q1.pop_front() : q0.pop_front();
        run = (s == own) ? ((run < MAXB) ? run + 1 : run) : 1;
        own = s;
        last = s;
        exp_data = {(s == 1), w};
        sb.push_back(exp_data);
      end
      if (src0_wr) begin
        if (n0 < DEPTH) q0.push_back(src0_data); else exp_ovf[0] = 1'b1;
      end
      if (src1_wr) begin
        if (n1 < DEPTH) q1.push_back(src1_data); else exp_ovf[1] = 1'b1;
      end
    end
    armed = 1'b1;
  end

  // Monitor: output timing, scoreboard order, data retention, and buffer flags.
  always @(negedge clk) begin : monitor
    logic [W:0] e;
    if (armed) begin
      chk("out_wr", 64'(out_wr), 64'(exp_wr));
      if (out_wr === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word at %0t: got %0h expected no write", $time, out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e));
        end
      end else begin
        chk("data_hold", 64'(out_data), 64'(exp_data));
      end
      chk("src0_full",  64'(src0_full),  64'(q0.size() == DEPTH));
      chk("src0_afull", 64'(src0_afull), 64'(q0.size() >= DEPTH - THR));
      chk("src1_full",  64'(src1_full),  64'(q1.size() == DEPTH));
      chk("src1_afull", 64'(src1_afull), 64'(q1.size() >= DEPTH - THR));
      chk("overflow",   64'(overflow),   64'(exp_ovf));
    end
  end

  // Apply one cycle of stimulus with fresh random data words.
  task automatic step(input bit w0, input bit w1, input bit af, input bit r);
    src0_wr   = w0;
    src0_data = $urandom;
    src1_wr   = w1;
    src1_data = $urandom;
    out_afull = af;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // Single-source latency: three back-to-back words from source 0.
    idle(7);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    // Burst limit: preload both buffers under backpressure, then release.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(12);
    // Backpressure in the middle of an 8-word source-1 stream.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, (i < 3), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    // Overflow: six writes into a held source-1 buffer.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    // Reset while source 1 owns the output with three words buffered.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);
    // Tie after idle with source 1 served last.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);
    // Randomised traffic with sporadic backpressure and resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 3) == 0, ($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 400) == 0);
    for (int i = 0; i < 40 && (sb.size() + q0.size() + q1.size()) != 0; i++) idle(1);
    idle(2);
    chk("drained", 64'(sb.size() + q0.size() + q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
